// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU/register-file instruction sequencer.
package alu_seq_pkg;

   // Instruction modes as presented on ins_mode_i
   typedef enum logic [1:0] {
      MODE_NOP  = 2'b00,
      MODE_LDI  = 2'b01,
      MODE_ALU  = 2'b10,
      MODE_NOWB = 2'b11
   } mode_t;

   // Datapath write-mux selections
   localparam logic [1:0] MUX_ALU = 2'b00;
   localparam logic [1:0] MUX_IMM = 2'b01;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DISPATCH,
      ST_EXEC,
      ST_WAIT,
      ST_WB
   } state_t;

endpackage

// File: rtl/alu_reg_seq.sv
// Instruction sequencer for the ALU + register-file datapath.
// Accepts one instruction over valid/ready, drives registered datapath
// controls, waits for the datapath result and returns it to the requester.
// Optional result-valid timeout: define ALU_SEQ_TIMEOUT_EN.
module alu_reg_seq
   import alu_seq_pkg::*;
#(
   parameter int DW      = 16,
   parameter int AW      = 4,
   parameter int OPW     = 8,
   parameter int TMO_CYC = 15
) (
   input  logic           clk,
   input  logic           a_reset_l,
   input  logic           ins_valid_i,
   output logic           ins_ready_o,
   input  logic [1:0]     ins_mode_i,
   input  logic [OPW-1:0] ins_op_i,
   input  logic [AW-1:0]  ins_ra_i,
   input  logic [AW-1:0]  ins_rb_i,
   input  logic [AW-1:0]  ins_rd_i,
   input  logic [3:0]     ins_seg_i,
   input  logic [DW-1:0]  ins_imm_i,
   output logic [DW-1:0]  dp_data_o,
   output logic [1:0]     dp_mux_sel_o,
   output logic [3:0]     dp_seg_o,
   output logic [AW-1:0]  dp_adr_a_o,
   output logic [AW-1:0]  dp_adr_b_o,
   output logic [AW-1:0]  dp_adr_w_o,
   output logic [OPW-1:0] dp_op_o,
   output logic           dp_we_o,
   input  logic           dp_valid_i,
   input  logic [DW-1:0]  dp_data_i,
   output logic           res_valid_o,
   output logic [DW-1:0]  res_data_o,
   output logic           err_o
);

   state_t         state;
   mode_t          mode_q;
   logic [OPW-1:0] op_q;
   logic [AW-1:0]  ra_q;
   logic [AW-1:0]  rb_q;
   logic [AW-1:0]  rd_q;
   logic [3:0]     seg_q;
   logic [DW-1:0]  imm_q;

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam logic [3:0] TMO_LAST = 4'(TMO_CYC - 1);
   logic [3:0] tmo_cnt;
   logic       err_q;
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   // Sequencer FSM; every datapath control and result output is registered here
   always_ff @(posedge clk) begin
      if (!a_reset_l) begin
         state        <= ST_IDLE;
         ins_ready_o  <= 1'b1;
         mode_q       <= MODE_NOP;
         op_q         <= '0;
         ra_q         <= '0;
         rb_q         <= '0;
         rd_q         <= '0;
         seg_q        <= '0;
         imm_q        <= '0;
         dp_data_o    <= '0;
         dp_mux_sel_o <= '0;
         dp_seg_o     <= '0;
         dp_adr_a_o   <= '0;
         dp_adr_b_o   <= '0;
         dp_adr_w_o   <= '0;
         dp_op_o      <= '0;
         dp_we_o      <= 1'b0;
         res_valid_o  <= 1'b0;
         res_data_o   <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
         tmo_cnt      <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         // strobes are single-cycle unless re-asserted below
         dp_we_o     <= 1'b0;
         res_valid_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ins_valid_i && ins_ready_o) begin
                  mode_q      <= mode_t'(ins_mode_i);
                  op_q        <= ins_op_i;
                  ra_q        <= ins_ra_i;
                  rb_q        <= ins_rb_i;
                  rd_q        <= ins_rd_i;
                  seg_q       <= ins_seg_i;
                  imm_q       <= ins_imm_i;
                  ins_ready_o <= 1'b0;
                  state       <= ST_DISPATCH;
               end
            end
            ST_DISPATCH: begin
               case (mode_q)
                  MODE_NOP: begin
                     ins_ready_o <= 1'b1;
                     state       <= ST_IDLE;
                  end
                  MODE_LDI: begin
                     // WB controls are loaded on entry so they are live during WB
                     dp_mux_sel_o <= MUX_IMM;
                     dp_data_o    <= imm_q;
                     dp_seg_o     <= seg_q;
                     dp_adr_w_o   <= rd_q;
                     dp_we_o      <= 1'b1;
                     res_valid_o  <= 1'b1;
                     res_data_o   <= imm_q;
                     state        <= ST_WB;
                  end
                  MODE_ALU, MODE_NOWB: begin
                     dp_adr_a_o   <= ra_q;
                     dp_adr_b_o   <= rb_q;
                     dp_op_o      <= op_q;
                     dp_seg_o     <= seg_q;
                     dp_mux_sel_o <= MUX_ALU;
                     state        <= ST_EXEC;
                  end
               endcase
            end
            ST_EXEC: begin
`ifdef ALU_SEQ_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (dp_valid_i) begin
                  res_data_o  <= dp_data_i;
                  res_valid_o <= 1'b1;
                  if (mode_q == MODE_ALU) begin
                     dp_we_o    <= 1'b1;
                     dp_adr_w_o <= rd_q;
                     state      <= ST_WB;
                  end else begin
                     ins_ready_o <= 1'b1;
                     state       <= ST_IDLE;
                  end
               end
`ifdef ALU_SEQ_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  err_q       <= 1'b1;
                  ins_ready_o <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 4'd1;
               end
`endif
            end
            ST_WB: begin
               ins_ready_o <= 1'b1;
               state       <= ST_IDLE;
            end
            default: begin
               ins_ready_o <= 1'b1;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
